// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: data-memory load/store, load formatting, sticky misalignment flag.
// Define MEM_SUBWORD_EN for byte/halfword accesses; otherwise every access is a full word.
module mem_wb_stage #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DMEM_ADDR_BITS = 17
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DATA_WIDTH-1:0]    alu_resultM_i,
    input  logic [DATA_WIDTH-1:0]    write_dataM_i,
    input  logic [11:7]              rdM_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4M_i,
    input  logic [2:0]               funct3M_i,
    input  logic                     reg_writeM_i,
    input  logic [1:0]               result_srcM_i,
    input  logic                     mem_writeM_i,
    input  logic                     stall_i,
    output logic [DATA_WIDTH-1:0]    alu_resultW_o,
    output logic [DATA_WIDTH-1:0]    read_dataW_o,
    output logic [4:0]               rdW_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4W_o,
    output logic                     reg_writeW_o,
    output logic [1:0]               result_srcW_o,
    output logic                     misaligned_o
);
    localparam int WORDS  = 2 ** (DMEM_ADDR_BITS - 2);
    localparam int NLANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] dmem [WORDS];

    logic [DMEM_ADDR_BITS-1:0] addr_p0;
    logic [DMEM_ADDR_BITS-3:0] widx_p0;
    logic [1:0]                off_p0;
    logic [DATA_WIDTH-1:0]     rword_p0;
    logic [DATA_WIDTH-1:0]     ld_data_p0;
    logic [DATA_WIDTH-1:0]     st_data_p0;
    logic [NLANES-1:0]         st_be_p0;
    logic                      is_load_p0;
    logic                      ld_mis_p0;
    logic                      st_mis_p0;
    logic                      mis_evt_p0;
    logic                      st_en_p0;

    logic [DATA_WIDTH-1:0]     alu_result_p1;
    logic [DATA_WIDTH-1:0]     read_data_p1;
    logic [4:0]                rd_p1;
    logic [ADDRESS_WIDTH-1:0]  pc_plus4_p1;
    logic                      reg_write_p1;
    logic [1:0]                result_src_p1;
    logic                      misaligned_p1;

    // ---- M stage: address decode and combinational read ----
    assign addr_p0    = alu_resultM_i[DMEM_ADDR_BITS-1:0];
    assign widx_p0    = addr_p0[DMEM_ADDR_BITS-1:2];
    assign off_p0     = addr_p0[1:0];
    assign rword_p0   = dmem[widx_p0];
    assign is_load_p0 = (result_srcM_i == 2'b01);

`ifdef MEM_SUBWORD_EN
    function automatic logic [DATA_WIDTH-1:0] format_load(
        input logic [DATA_WIDTH-1:0] w,
        input logic [1:0]            off,
        input logic [2:0]            f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'b00:   format_load = f3[2] ? {{(DATA_WIDTH-8){1'b0}}, b}  : {{(DATA_WIDTH-8){b[7]}}, b};
            2'b01:   format_load = f3[2] ? {{(DATA_WIDTH-16){1'b0}}, h} : {{(DATA_WIDTH-16){h[15]}}, h};
            default: format_load = w;
        endcase
    endfunction

    // Load and store decode funct3 differently: loads key on [1:0], stores on the full code.
    always_comb begin
        ld_mis_p0  = 1'b0;
        st_mis_p0  = 1'b0;
        st_be_p0   = '1;
        st_data_p0 = write_dataM_i;
        case (funct3M_i[1:0])
            2'b00:   ld_mis_p0 = 1'b0;
            2'b01:   ld_mis_p0 = off_p0[0];
            default: ld_mis_p0 = (off_p0 != 2'b00);
        endcase
        case (funct3M_i)
            3'b000: begin
                st_be_p0   = NLANES'(1) << off_p0;
                st_data_p0 = {NLANES{write_dataM_i[7:0]}};
            end
            3'b001: begin
                st_be_p0   = off_p0[1] ? 4'b1100 : 4'b0011;
                st_data_p0 = {2{write_dataM_i[15:0]}};
                st_mis_p0  = off_p0[0];
            end
            default: st_mis_p0 = (off_p0 != 2'b00);
        endcase
    end

    assign ld_data_p0 = format_load(rword_p0, off_p0, funct3M_i);
`else
    logic unused_funct3;

    assign unused_funct3 = ^funct3M_i;
    assign ld_mis_p0     = (off_p0 != 2'b00);
    assign st_mis_p0     = (off_p0 != 2'b00);
    assign st_be_p0      = '1;
    assign st_data_p0    = write_dataM_i;
    assign ld_data_p0    = rword_p0;
`endif

    assign mis_evt_p0 = !stall_i && ((is_load_p0 && ld_mis_p0) || (mem_writeM_i && st_mis_p0));
    assign st_en_p0   = mem_writeM_i && !stall_i && !st_mis_p0;

    // A store presented while reset is high is dropped; contents are never cleared.
    always_ff @(posedge clk_i) begin
        if (!rst_i && st_en_p0) begin
            for (int i = 0; i < NLANES; i++) begin
                if (st_be_p0[i]) begin
                    dmem[widx_p0][8*i +: 8] <= st_data_p0[8*i +: 8];
                end
            end
        end
    end

    // ---- M/W boundary: writeback register ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_result_p1 <= '0;
            read_data_p1  <= '0;
            rd_p1         <= '0;
            pc_plus4_p1   <= '0;
            reg_write_p1  <= 1'b0;
            result_src_p1 <= '0;
            misaligned_p1 <= 1'b0;
        end else begin
            if (!stall_i) begin
                alu_result_p1 <= alu_resultM_i;
                read_data_p1  <= (is_load_p0 && !ld_mis_p0) ? ld_data_p0 : '0;
                rd_p1         <= rdM_i;
                pc_plus4_p1   <= pc_plus4M_i;
                reg_write_p1  <= reg_writeM_i;
                result_src_p1 <= result_srcM_i;
            end
            if (mis_evt_p0) begin
                misaligned_p1 <= 1'b1;
            end
        end
    end

    assign alu_resultW_o = alu_result_p1;
    assign read_dataW_o  = read_data_p1;
    assign rdW_o         = rd_p1;
    assign pc_plus4W_o   = pc_plus4_p1;
    assign reg_writeW_o  = reg_write_p1;
    assign result_srcW_o = result_src_p1;
    assign misaligned_o  = misaligned_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a byte-array memory model, with directed literal pins.
module tb_mem_wb_stage;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int AB   = 17;
    localparam int MASK = (1 << AB) - 1;
`ifdef MEM_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] alu_resultM_i = '0;
    logic [DW-1:0] write_dataM_i = '0;
    logic [4:0]    rdM_i = '0;
    logic [AW-1:0] pc_plus4M_i = '0;
    logic [2:0]    funct3M_i = '0;
    logic          reg_writeM_i = 1'b0;
    logic [1:0]    result_srcM_i = '0;
    logic          mem_writeM_i = 1'b0;
    logic          stall_i = 1'b0;
    logic [DW-1:0] alu_resultW_o;
    logic [DW-1:0] read_dataW_o;
    logic [4:0]    rdW_o;
    logic [AW-1:0] pc_plus4W_o;
    logic          reg_writeW_o;
    logic [1:0]    result_srcW_o;
    logic          misaligned_o;

    always #5 clk_i = ~clk_i;

    mem_wb_stage #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DMEM_ADDR_BITS(AB)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_resultM_i(alu_resultM_i), .write_dataM_i(write_dataM_i), .rdM_i(rdM_i),
        .pc_plus4M_i(pc_plus4M_i), .funct3M_i(funct3M_i), .reg_writeM_i(reg_writeM_i),
        .result_srcM_i(result_srcM_i), .mem_writeM_i(mem_writeM_i), .stall_i(stall_i),
        .alu_resultW_o(alu_resultW_o), .read_dataW_o(read_dataW_o), .rdW_o(rdW_o),
        .pc_plus4W_o(pc_plus4W_o), .reg_writeW_o(reg_writeW_o), .result_srcW_o(result_srcW_o),
        .misaligned_o(misaligned_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mmem [0:MASK];
    logic [31:0] e_alu = '0, e_rdata = '0, e_pc = '0;
    logic [4:0]  e_rd = '0;
    logic [1:0]  e_rs = '0;
    logic        e_rw = 1'b0, e_mis = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic int ld_size(input logic [2:0] f3);
        if (!SUB) return 4;
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int st_size(input logic [2:0] f3);
        if (!SUB) return 4;
        case (f3)
            3'b000:  return 1;
            3'b001:  return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ld_signed(input logic [2:0] f3);
        return SUB && (f3 == 3'b000 || f3 == 3'b001);
    endfunction

    // Reference model: advance at each edge from pre-edge memory, then compare just after the edge.
    initial begin
        forever begin
            int          a;
            int          sz;
            logic [31:0] rv;
            @(posedge clk_i);
            if (rst_i) begin
                e_alu = '0; e_rdata = '0; e_pc = '0; e_rd = '0; e_rs = '0; e_rw = 1'b0; e_mis = 1'b0;
            end else if (!stall_i) begin
                a  = int'(alu_resultM_i) & MASK;
                rv = '0;
                if (result_srcM_i == 2'b01) begin
                    sz = ld_size(funct3M_i);
                    if (a % sz != 0) begin
                        e_mis = 1'b1;
                    end else begin
                        for (int i = 0; i < sz; i++) rv |= 32'(mmem[(a + i) & MASK]) << (8 * i);
                        if (ld_signed(funct3M_i) && rv[8*sz-1]) rv |= 32'hFFFF_FFFF << (8 * sz);
                    end
                end
                if (mem_writeM_i) begin
                    sz = st_size(funct3M_i);
                    if (a % sz != 0) e_mis = 1'b1;
                    else for (int i = 0; i < sz; i++) mmem[(a + i) & MASK] = 8'(write_dataM_i >> (8 * i));
                end
                e_alu = alu_resultM_i; e_rdata = rv; e_pc = pc_plus4M_i;
                e_rd = rdM_i; e_rs = result_srcM_i; e_rw = reg_writeM_i;
            end
            #1;
            check("alu_result", alu_resultW_o, e_alu);
            check("rd", 32'(rdW_o), 32'(e_rd));
            check("pc_plus4", pc_plus4W_o, e_pc);
            check("reg_write", 32'(reg_writeW_o), 32'(e_rw));
            check("result_src", 32'(result_srcW_o), 32'(e_rs));
            check("misaligned", 32'(misaligned_o), 32'(e_mis));
            if (e_rs == 2'b01) check("read_data", read_dataW_o, e_rdata);
        end
    end

    task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [2:0] f3,
                         input logic [1:0] rs, input logic mw, input logic rw, input logic st);
        alu_resultM_i = alu;
        write_dataM_i = wd;
        funct3M_i     = f3;
        result_srcM_i = rs;
        mem_writeM_i  = mw;
        reg_writeM_i  = rw;
        stall_i       = st;
        rdM_i         = 5'($urandom);
        pc_plus4M_i   = $urandom;
        @(negedge clk_i);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_alu"}, alu_resultW_o, 32'h0);
        check({tag, "_rdata"}, read_dataW_o, 32'h0);
        check({tag, "_rd"}, 32'(rdW_o), 32'h0);
        check({tag, "_pc"}, pc_plus4W_o, 32'h0);
        check({tag, "_rw"}, 32'(reg_writeW_o), 32'h0);
        check({tag, "_rs"}, 32'(result_srcW_o), 32'h0);
        check({tag, "_mis"}, 32'(misaligned_o), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge clk_i);
        @(negedge clk_i);
        check_zero("reset");
        rst_i = 1'b0;

        // Known contents for the region the random phase touches.
        for (int i = 0; i < 256; i++) issue(32'(i * 4), {16'hC0DE, 16'(i)}, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0);

`ifdef MEM_SUBWORD_EN
        issue(32'h100, 32'h0, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0);
        issue(32'h101, 32'hABCD_EFFF, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0);
        issue(32'h101, 32'h0, 3'b000, 2'b01, 1'b0, 1'b1, 1'b0);
        check("lb_0x101", read_dataW_o, 32'hFFFF_FFFF);
        issue(32'h101, 32'h0, 3'b100, 2'b01, 1'b0, 1'b1, 1'b0);
        check("lbu_0x101", read_dataW_o, 32'h0000_00FF);
        issue(32'h100, 32'h0, 3'b010, 2'b01, 1'b0, 1'b1, 1'b0);
        check("lw_after_sb", read_dataW_o, 32'h0000_FF00);
`endif

        issue(32'h100, 32'h8081_8283, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0);
        issue(32'h100, 32'h0, 3'b010, 2'b01, 1'b0, 1'b1, 1'b0);
        check("lw_0x100", read_dataW_o, 32'h8081_8283);
        check("mis_clear", 32'(misaligned_o), 32'h0);

        issue(32'h102, 32'hDEAD_BEEF, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0);
        check("mis_set", 32'(misaligned_o), 32'h1);
        issue(32'h100, 32'h0, 3'b010, 2'b01, 1'b0, 1'b1, 1'b0);
        check("lw_unchanged", read_dataW_o, 32'h8081_8283);
        issue(32'h103, 32'h0, 3'b001, 2'b01, 1'b0, 1'b1, 1'b0);
        check("mis_load_zero", read_dataW_o, 32'h0);
        check("mis_load_rw", 32'(reg_writeW_o), 32'h1);
        check("mis_sticky", 32'(misaligned_o), 32'h1);

        issue(32'h55, 32'h0, 3'b000, 2'b00, 1'b0, 1'b1, 1'b0);
        check("pre_stall_alu", alu_resultW_o, 32'h55);
        for (int i = 0; i < 3; i++) begin
            issue(32'h200, 32'hCAFE_F00D, 3'b010, 2'b00, 1'b1, 1'b0, 1'b1);
            check("stall_alu", alu_resultW_o, 32'h55);
            check("stall_rw", 32'(reg_writeW_o), 32'h1);
        end
        issue(32'h200, 32'hCAFE_F00D, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0);
        check("release_alu", alu_resultW_o, 32'h200);
        check("release_rw", 32'(reg_writeW_o), 32'h0);
        issue(32'h200, 32'h0, 3'b010, 2'b01, 1'b0, 1'b1, 1'b0);
        check("lw_0x200", read_dataW_o, 32'hCAFE_F00D);

        issue(32'h0002_0004, 32'h1234_5678, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0);
        issue(32'h0000_0004, 32'h0, 3'b010, 2'b01, 1'b0, 1'b1, 1'b0);
        check("alias_data", read_dataW_o, 32'h1234_5678);
        check("alias_alu", alu_resultW_o, 32'h4);

        // Reset mid-stream with a store on the inputs: outputs clear at once, store dropped.
        alu_resultM_i = 32'h300; write_dataM_i = 32'h0BAD_0BAD; funct3M_i = 3'b010;
        result_srcM_i = 2'b00; mem_writeM_i = 1'b1; stall_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check_zero("midreset");
        @(negedge clk_i);
        rst_i = 1'b0;
        issue(32'h0, 32'h0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        issue(32'h300, 32'h0, 3'b010, 2'b01, 1'b0, 1'b1, 1'b0);
        check("lw_0x300", read_dataW_o, 32'hC0DE_00C0);
        check("mis_after_reset", 32'(misaligned_o), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            int          kind;
            logic [31:0] addr;
            logic [1:0]  rs;
            logic        mw;
            rst_i = ($urandom_range(0, 149) == 0);
            kind  = int'($urandom_range(0, 2));
            addr  = ($urandom & 32'hFFFE_0000) | $urandom_range(0, 1023);
            rs    = $urandom_range(0, 1) ? 2'b00 : 2'b10;
            mw    = 1'b0;
            if (kind == 1) rs = 2'b01;
            if (kind == 2) mw = 1'b1;
            issue(addr, $urandom, 3'($urandom), rs, mw, 1'($urandom), $urandom_range(0, 6) == 0);
        end
        rst_i = 1'b0;
        @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
